// File: rtl/seg7_digit_sequencer.sv
// Shows an unsigned binary value on one 7-segment digit position, MS digit first.
// Binary->BCD by sequential double-dabble, then timed show/blank per digit.
module seg7_digit_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NDIG  = 3,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned GAP   = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       digit,
    output logic             dp,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = 4 * NDIG;
    localparam int unsigned TW = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW = $clog2(TW + 1);
    localparam int unsigned KW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    function automatic logic bcd_fits();
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < NDIG; i++) p = p * 10;
        return p > (64'd1 << WIDTH);
    endfunction

    if (!bcd_fits()) begin : g_bad_ndig
        $error("NDIG too small: 10**NDIG must exceed 2**WIDTH");
    end
    if (DWELL < 1 || GAP < 1 || WIDTH < 2) begin : g_bad_timing
        $error("DWELL and GAP must be >= 1, WIDTH >= 2");
    end

    typedef enum logic [1:0] {IDLE, CONV, SHOW, BLANK} state_e;

    state_e              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [KW-1:0]       conv_q, conv_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          digit_q, digit_d;
    logic                dp_q, dp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] dabble;
    logic [IW-1:0]       lead;

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        conv_d  = conv_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dabble = {bcd_adj, shift_q} << 1;

        // Leading-zero suppression looks at the post-shift value so the last
        // conversion cycle can pick the start digit without an extra state.
        lead = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (dabble[WIDTH + 4*i +: 4] != 4'd0) lead = IW'(i);
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    state_d = CONV;
                    shift_d = in_data;
                    bcd_d   = '0;
                    conv_d  = KW'(WIDTH);
                end
            end
            CONV: begin
                bcd_d   = dabble[BW+WIDTH-1:WIDTH];
                shift_d = dabble[WIDTH-1:0];
                conv_d  = conv_q - KW'(1);
                if (conv_q == KW'(1)) begin
                    state_d = SHOW;
                    idx_d   = lead;
                    cnt_d   = CW'(DWELL);
                end
            end
            SHOW: begin
                if (cnt_q == CW'(1)) begin
                    state_d = BLANK;
                    cnt_d   = CW'(GAP);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            BLANK: begin
                if (cnt_q == CW'(1)) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = SHOW;
                        idx_d   = idx_q - IW'(1);
                        cnt_d   = CW'(DWELL);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        digit_d = (state_d == SHOW) ? bcd_d[{idx_d, 2'b00} +: 4] : 4'hF;
        dp_d    = (state_d == SHOW) && (idx_d == '0);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_q == BLANK) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            shift_q <= '0;
            conv_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            digit_q <= 4'hF;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            conv_q  <= conv_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign digit    = digit_q;
    assign dp       = dp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign in_ready = ready_q;

endmodule

// File: doc/seg7_digit_sequencer.md
Name: seg7_digit_sequencer

Overview:
Presents a multi-digit unsigned decimal number on the single 7-segment display, one digit at a time. It accepts a binary result through a valid/ready handshake and converts it to BCD sequentially using shift-add-3 (double-dabble). It then steps through the digits most-significant first, with a timed dwell per digit and a blank gap between digits. Its 4-bit digit-code output drives the segment decoder directly; code 4'hF decodes to all segments off.

Parameters:
WIDTH, 8, bit width of the input value.
NDIG, 3, BCD digits produced; 10^NDIG > 2^WIDTH is required (elaboration-time check).
DWELL, 1000, clock cycles each digit is shown (>=1).
GAP, 250, blank cycles after each digit (>=1).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a value to display
in_ready  output  1  block idle, able to accept
in_data  input  WIDTH  unsigned binary value
digit  output  4  BCD digit 0-9 to decoder; 4'hF = blank
dp  output  1  decimal point, marks last (units) digit
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (clk edge with reset=1) puts the block in IDLE from any state, including mid-conversion or mid-display. Reset values: digit=4'hF, dp=0, busy=0, done=0, in_ready=1. All counters are zeroed and the BCD register is cleared.
- All outputs are registered.
- States are IDLE, CONV, SHOW, BLANK.
- IDLE:
  - in_ready=1, digit=4'hF.
  - Transfer occurs when in_valid && in_ready at a clk edge. in_data is captured and the state moves to CONV.
  - in_valid is ignored in every other state. No queuing.
- CONV:
  - Runs exactly WIDTH cycles. Each cycle, every BCD nibble >=5 gets +3, then {bcd, shift} is shifted left by one.
  - On the last cycle, the start index is set to the most-significant non-zero digit. Leading zeros are suppressed; if the value is 0, the units digit is used.
  - The state then moves to SHOW.
  - Suppressed digits consume no cycles. Interior zeros (e.g. the 0 in 205) are shown.
- SHOW:
  - digit = current BCD nibble for exactly DWELL cycles.
  - dp=1 only while showing the units digit.
  - The state then moves to BLANK.
- BLANK:
  - digit=4'hF, dp=0 for exactly GAP cycles.
  - If the units digit has just been shown, the state moves to IDLE. Otherwise the index decrements and the state moves to SHOW.
- done=1 for exactly the first IDLE cycle after the final BLANK. in_ready is also 1 in that cycle, so a back-to-back transfer is legal in the same cycle.
- busy = (state != IDLE).
- Total latency, from the accept edge to the done cycle, is WIDTH + k*(DWELL+GAP) cycles, where k is the number of displayed digits.
- The dwell counter width is clog2(max(DWELL,GAP)+1). It reloads on every state entry and never wraps.
- An in_data value at max (2^WIDTH−1) must convert exactly, with no overflow of NDIG nibbles.

Test Plan:
Use WIDTH=8, NDIG=3, DWELL=4, GAP=2 for all scenarios.
1. Reset, then hold idle -> digit=F, dp=0, busy=0, in_ready=1, done=0 for 10 cycles.
2. Send in_data=205 -> 8 CONV cycles; then digit 2 for 4 cycles, F for 2, 0 for 4, F for 2, 5 with dp=1 for 4, F for 2. done pulses 26 cycles after accept.
3. Send in_data=0 -> single digit 0 with dp=1 for 4 cycles, then F for 2, done at 14 cycles. Send 7 -> only digit 7 is shown.
4. Send in_data=255 while holding in_valid=1 with a changing in_data throughout -> display 2,5,5 unaffected. in_ready=0 while busy. A second value is accepted on the done cycle, and its display begins 8 cycles later.
5. Assert reset for 1 cycle during the SHOW of the second digit of 123 -> the next cycle gives digit=F, busy=0, in_ready=1, done=0. A new value of 9 then displays normally.
6. Sweep all 256 inputs with a scoreboard -> each displayed digit sequence equals the decimal string of the input without leading zeros. dp is set on the last digit only, and there is exactly one done per accept.
